// File: rtl/card1_pll_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and the card-level PLL/reset fabric.
// master: the sequencer; slave: the PLL and downstream domains.
interface card1_pll_reset_seq_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   pll_locked;
    logic                   restart;
    logic                   pll_areset;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   ready;
    logic                   fault;
    logic [3:0]             retry_cnt;
    logic [7:0]             lock_loss_cnt;
    logic [2:0]             state;

    modport master (
        input  pll_locked, restart,
        output pll_areset, domain_rst_n, ready, fault, retry_cnt, lock_loss_cnt, state
    );

    modport slave (
        output pll_locked, restart,
        input  pll_areset, domain_rst_n, ready, fault, retry_cnt, lock_loss_cnt, state
    );
endinterface

// File: rtl/card1_pll_reset_seq.sv
// PLL power-up/recovery sequencer: pulses areset, qualifies lock, releases
// domain resets in staggered order, retries on timeout and faults when exhausted.
module card1_pll_reset_seq #(
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP         = 8,
    parameter int NUM_DOMAINS         = 4,
    parameter int MAX_RETRIES         = 3
) (
    input logic                   inclk0,
    input logic                   areset_n,
    card1_pll_reset_seq_if.master bus
);
    localparam int REL_LAST = (NUM_DOMAINS - 1) * RELEASE_GAP;
    localparam int PW = (RESET_PULSE_CYCLES  > 1) ? $clog2(RESET_PULSE_CYCLES)  : 1;
    localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int SW = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int RW = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ASSERT_RST = 3'd1,
        WAIT_LOCK  = 3'd2,
        STABLE     = 3'd3,
        RELEASE    = 3'd4,
        RUN        = 3'd5,
        FAULT      = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, locked_s_q;
    logic [PW-1:0]          pulse_q, pulse_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [SW-1:0]          stab_q, stab_d;
    logic [RW-1:0]          rel_q, rel_d;
    logic [3:0]             retry_cnt_q, retry_cnt_d, retry_inc;
    logic [7:0]             lock_loss_cnt_q, lock_loss_cnt_d;
    logic                   pll_areset_q, pll_areset_d;
    logic [NUM_DOMAINS-1:0] domain_rst_n_q, domain_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= bus.pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            state_q         <= IDLE;
            pulse_q         <= '0;
            tmo_q           <= '0;
            stab_q          <= '0;
            rel_q           <= '0;
            retry_cnt_q     <= '0;
            lock_loss_cnt_q <= '0;
            pll_areset_q    <= 1'b1;
            domain_rst_n_q  <= '0;
            ready_q         <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            pulse_q         <= pulse_d;
            tmo_q           <= tmo_d;
            stab_q          <= stab_d;
            rel_q           <= rel_d;
            retry_cnt_q     <= retry_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
            pll_areset_q    <= pll_areset_d;
            domain_rst_n_q  <= domain_rst_n_d;
            ready_q         <= ready_d;
            fault_q         <= fault_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pulse_d         = pulse_q;
        tmo_d           = tmo_q;
        stab_d          = stab_q;
        rel_d           = rel_q;
        retry_cnt_d     = retry_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;
        retry_inc       = retry_cnt_q + 4'd1;

        if (bus.restart) begin
            state_d     = ASSERT_RST;
            pulse_d     = '0;
            retry_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ASSERT_RST;
                    pulse_d = '0;
                end
                ASSERT_RST: begin
                    if (pulse_q == PW'(RESET_PULSE_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        tmo_d   = '0;
                    end else begin
                        pulse_d = pulse_q + 1'b1;
                    end
                end
                WAIT_LOCK, STABLE: begin
                    // Timeout spans both states so a chattering lock cannot stall forever.
                    if (tmo_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_cnt_d = retry_inc;
                        pulse_d     = '0;
                        state_d     = (retry_inc < 4'(MAX_RETRIES)) ? ASSERT_RST : FAULT;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                        if (state_q == WAIT_LOCK) begin
                            if (locked_s_q) begin
                                state_d = STABLE;
                                stab_d  = SW'(1);
                            end
                        end else if (!locked_s_q) begin
                            state_d = WAIT_LOCK;
                        end else if (stab_q >= SW'(LOCK_STABLE_CYCLES - 1)) begin
                            state_d = RELEASE;
                            rel_d   = '0;
                        end else begin
                            stab_d = stab_q + 1'b1;
                        end
                    end
                end
                RELEASE, RUN: begin
                    if (!locked_s_q) begin
                        state_d = ASSERT_RST;
                        pulse_d = '0;
                        if (lock_loss_cnt_q != '1) lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                    end else if (state_q == RELEASE) begin
                        if (rel_q == RW'(REL_LAST)) begin
                            state_d     = RUN;
                            retry_cnt_d = '0;
                        end else begin
                            rel_d = rel_q + 1'b1;
                        end
                    end
                end
                FAULT: state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so every port comes straight from a flop.
        pll_areset_d = (state_d == IDLE) || (state_d == ASSERT_RST) || (state_d == FAULT);
        ready_d      = (state_d == RUN);
        fault_d      = (state_d == FAULT);
        for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            domain_rst_n_d[k] = (state_d == RUN) ||
                                ((state_d == RELEASE) && (rel_d >= RW'(k * RELEASE_GAP)));
        end
    end

    assign bus.pll_areset    = pll_areset_q;
    assign bus.domain_rst_n  = domain_rst_n_q;
    assign bus.ready         = ready_q;
    assign bus.fault         = fault_q;
    assign bus.retry_cnt     = retry_cnt_q;
    assign bus.lock_loss_cnt = lock_loss_cnt_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_card1_pll_reset_seq.sv
// Bench for card1_pll_reset_seq: directed vector table, corner-case sequences
// and randomized lock/restart stimulus against a behavioural model.
module tb_card1_pll_reset_seq;
    localparam int P = 4, T = 32, S = 8, G = 2, N = 4, M = 2;

    logic inclk0   = 1'b0;
    logic areset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    card1_pll_reset_seq_if #(.NUM_DOMAINS(N)) bus ();

    card1_pll_reset_seq #(
        .RESET_PULSE_CYCLES (P),
        .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_STABLE_CYCLES (S),
        .RELEASE_GAP        (G),
        .NUM_DOMAINS        (N),
        .MAX_RETRIES        (M)
    ) u_dut (
        .inclk0  (inclk0),
        .areset_n(areset_n),
        .bus     (bus)
    );

    always #5 inclk0 = ~inclk0;

    // Behavioural model: phase number, cycles spent in phase, lock history.
    int   m_phase, m_el, m_tmo, m_run, m_retry, m_ll;
    logic lq[$];

    function automatic logic [21:0] pack(input logic [2:0] st, input logic ar,
                                         input logic [N-1:0] dom, input logic rdy,
                                         input logic flt, input logic [3:0] rty,
                                         input logic [7:0] ll);
        return {st, ar, dom, rdy, flt, rty, ll};
    endfunction

    function automatic logic [21:0] dut_vec();
        return pack(bus.state, bus.pll_areset, bus.domain_rst_n, bus.ready,
                    bus.fault, bus.retry_cnt, bus.lock_loss_cnt);
    endfunction

    function automatic logic [21:0] model_vec();
        logic [N-1:0] dom;
        for (int k = 0; k < N; k++) dom[k] = (m_phase == 5) || (m_phase == 4 && m_el >= k * G);
        return pack(3'(m_phase), (m_phase == 0 || m_phase == 1 || m_phase == 6), dom,
                    (m_phase == 5), (m_phase == 6), 4'(m_retry), 8'(m_ll));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_el = 0; m_tmo = 0; m_run = 0; m_retry = 0; m_ll = 0;
        lq.delete();
        lq.push_back(1'b0);
        lq.push_back(1'b0);
    endtask

    task automatic model_step(input logic lk, input logic rs);
        logic ls;
        ls = lq[0];
        void'(lq.pop_front());
        lq.push_back(lk);
        if (rs) begin
            m_phase = 1; m_el = 0; m_retry = 0;
        end else begin
            case (m_phase)
                0: begin m_phase = 1; m_el = 0; end
                1: if (m_el + 1 == P) begin m_phase = 2; m_tmo = 0; end else m_el++;
                2, 3: begin
                    if (m_tmo + 1 == T) begin
                        m_retry++;
                        m_phase = (m_retry < M) ? 1 : 6;
                        m_el = 0;
                    end else begin
                        m_tmo++;
                        if (m_phase == 2) begin
                            if (ls) begin m_phase = 3; m_run = 1; end
                        end else if (!ls) m_phase = 2;
                        else begin
                            m_run++;
                            if (m_run >= S) begin m_phase = 4; m_el = 0; end
                        end
                    end
                end
                4, 5: begin
                    if (!ls) begin
                        m_phase = 1; m_el = 0;
                        if (m_ll < 255) m_ll++;
                    end else if (m_phase == 4) begin
                        if (m_el == (N - 1) * G) begin m_phase = 5; m_retry = 0; end
                        else m_el++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic lk, input logic rs);
        bus.pll_locked = lk;
        bus.restart    = rs;
        @(posedge inclk0);
        if (areset_n) model_step(lk, rs);
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    typedef struct {
        logic       lk;
        logic       rs;
        int         n;
        logic [2:0] st;
        logic       ar;
        logic [N-1:0] dom;
        logic       rdy;
        logic       flt;
        logic [3:0] rty;
        logic [7:0] ll;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   cnt, attempts, cur;
        int   waits[4];
        bit   ok, saw_wait;
        logic lk_r;

        tbl[0]  = '{1'b0, 1'b0, 1, 3'd1, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 3, 3'd1, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1, 3'd2, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 4, 3'd2, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 2, 3'd2, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1, 3'd3, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 6, 3'd3, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 1, 3'd4, 1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 1, 3'd4, 1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 1, 3'd4, 1'b0, 4'h3, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 2, 3'd4, 1'b0, 4'h7, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[11] = '{1'b1, 1'b0, 2, 3'd4, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[12] = '{1'b1, 1'b0, 1, 3'd5, 1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[13] = '{1'b1, 1'b0, 5, 3'd5, 1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[14] = '{1'b0, 1'b0, 2, 3'd5, 1'b0, 4'hF, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[15] = '{1'b0, 1'b0, 1, 3'd1, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 8'd1};

        bus.pll_locked = 1'b0;
        bus.restart    = 1'b0;
        model_reset();
        repeat (3) @(posedge inclk0);
        #1;
        check("reset_state", 32'(dut_vec()), 32'(pack(3'd0, 1'b1, '0, 1'b0, 1'b0, 4'd0, 8'd0)));
        areset_n = 1'b1;

        // Nominal bring-up followed by lock loss in RUN.
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < tbl[i].n; c++) step(tbl[i].lk, tbl[i].rs);
            check($sformatf("row%0d", i), 32'(dut_vec()),
                  32'(pack(tbl[i].st, tbl[i].ar, tbl[i].dom, tbl[i].rdy, tbl[i].flt,
                           tbl[i].rty, tbl[i].ll)));
        end

        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin step(1'b1, 1'b0); ok = (bus.state == 3'd5); end
        check("relock_run", 32'(ok), 32'd1);
        check("relock_lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'd1);

        // Lock chatter in STABLE.
        step(1'b1, 1'b1);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 4; c++) begin step(1'b1, 1'b0); if (bus.state == 3'd3) cnt++; end
        step(1'b0, 1'b0);
        ok = 0; saw_wait = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            step(1'b1, 1'b0);
            if (bus.state == 3'd2) saw_wait = 1;
            ok = (bus.state == 3'd5);
        end
        check("chatter_back_to_wait", 32'(saw_wait), 32'd1);
        check("chatter_run", 32'(ok), 32'd1);

        // Never lock: two timed-out attempts then FAULT.
        step(1'b0, 1'b1);
        attempts = 0; cur = 0;
        for (int c = 0; c < 400 && bus.state != 3'd6; c++) begin
            step(1'b0, 1'b0);
            if (bus.state == 3'd2) cur++;
            else if (cur > 0) begin
                if (attempts < 4) waits[attempts] = cur;
                attempts++; cur = 0;
            end
        end
        check("timeout_attempts", 32'(attempts), 32'd2);
        check("timeout_wait0", 32'(waits[0]), 32'(T));
        check("timeout_wait1", 32'(waits[1]), 32'(T));
        check("fault_state", 32'(dut_vec()), 32'(pack(3'd6, 1'b1, '0, 1'b0, 1'b1, 4'd2, 8'd1)));
        repeat (5) step(1'b1, 1'b0);
        check("fault_sticky", 32'(bus.fault), 32'd1);

        // restart from FAULT, then restart mid-RELEASE.
        step(1'b1, 1'b1);
        check("restart_fault", 32'(dut_vec()), 32'(pack(3'd1, 1'b1, '0, 1'b0, 1'b0, 4'd0, 8'd1)));
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin step(1'b1, 1'b0); ok = (bus.domain_rst_n == 4'b0011); end
        check("reach_0011", 32'(ok), 32'd1);
        step(1'b1, 1'b1);
        check("restart_release", 32'(dut_vec()), 32'(pack(3'd1, 1'b1, '0, 1'b0, 1'b0, 4'd0, 8'd1)));

        // Randomized lock behaviour and occasional restarts.
        lk_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) lk_r = ~lk_r;
            step(lk_r, ($urandom_range(249) == 0));
        end

        // Async reset in RUN.
        step(1'b1, 1'b1);
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin step(1'b1, 1'b0); ok = (bus.state == 3'd5); end
        check("pre_async_run", 32'(ok), 32'd1);
        #1;
        areset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", 32'(dut_vec()), 32'(pack(3'd0, 1'b1, '0, 1'b0, 1'b0, 4'd0, 8'd0)));
        check("async_lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'd0);
        #3;
        areset_n = 1'b1;
        repeat (20) step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/card1_pll_reset_seq.md
Name: card1_pll_reset_seq

Overview:
Power-up and recovery sequencer for the card-level 4-output PLL (125/125/40/25 MHz from a 125 MHz reference). It runs on the free-running reference clock and drives the PLL areset. It qualifies the PLL lock signal and releases the per-domain resets in a staggered order. On loss of lock or lock timeout it re-initialises the PLL, with bounded retries and a sticky fault.

Parameters:
RESET_PULSE_CYCLES, 16, cycles pll_areset is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed from areset release to qualified lock
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release
RELEASE_GAP, 8, cycles between successive domain reset releases (>=1)
NUM_DOMAINS, 4, number of downstream reset outputs (one per PLL clock)
MAX_RETRIES, 3, timeout attempts allowed before FAULT (1..15)

Ports:
inclk0  in  1  reference clock, free-running, not PLL-derived
areset_n  in  1  asynchronous active-low reset
pll_locked  in  1  raw PLL locked, asynchronous to inclk0
restart  in  1  synchronous single-cycle request to re-run the full sequence
pll_areset  out  1  active-high PLL reset
domain_rst_n  out  NUM_DOMAINS  active-low reset per clock domain, bit k for c<k>
ready  out  1  all domains released and lock qualified
fault  out  1  sticky; retries exhausted
retry_cnt  out  4  timeout attempts in current sequence
lock_loss_cnt  out  8  saturating count of lock losses seen in RUN/RELEASE
state  out  3  IDLE=0 ASSERT_RST=1 WAIT_LOCK=2 STABLE=3 RELEASE=4 RUN=5 FAULT=6

Behaviour:
- Reset (areset_n=0, async): state=IDLE, pll_areset=1, domain_rst_n=all 0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, sync flops=0.
- pll_locked passes through a 2-flop synchroniser (locked_s). Latency from input to locked_s is 2 inclk0 edges. Only locked_s is used.
- IDLE: next cycle goes to ASSERT_RST.
- ASSERT_RST: pll_areset=1 for exactly RESET_PULSE_CYCLES cycles in-state, then WAIT_LOCK. On that transition the timeout counter is cleared and pll_areset drops on the first WAIT_LOCK cycle.
- Timeout counter: increments every cycle in WAIT_LOCK and STABLE. It is not cleared when STABLE falls back to WAIT_LOCK, so a chattering lock still times out.
- WAIT_LOCK: locked_s=1 goes to STABLE with the stable counter set to 1.
- STABLE: the stable counter increments while locked_s=1. When it reaches LOCK_STABLE_CYCLES, go to RELEASE. If locked_s=0, go to WAIT_LOCK.
- Timeout: the timeout counter reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or STABLE. Timeout has priority over lock qualification in the same cycle.
  - retry_cnt increments.
  - If the new retry_cnt < MAX_RETRIES, go to ASSERT_RST; otherwise go to FAULT.
- RELEASE:
  - domain_rst_n[0] goes high on the first RELEASE cycle.
  - Bit k goes high k*RELEASE_GAP cycles later.
  - One cycle after bit NUM_DOMAINS-1 goes high, go to RUN.
  - ready=1 and retry_cnt=0 from the first RUN cycle.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - On the next cycle: state=ASSERT_RST, domain_rst_n=all 0, ready=0, pll_areset=1.
  - lock_loss_cnt increments and saturates at 255.
  - retry_cnt is unchanged (lock loss is not a timeout).
- FAULT: pll_areset=1, domain_rst_n=all 0, ready=0, fault=1. Held until restart or areset_n.
- restart=1: highest priority, accepted in any state including FAULT and ASSERT_RST. On the next cycle:
  - state=ASSERT_RST with the pulse counter restarted.
  - retry_cnt=0, fault=0, domain_rst_n=all 0, ready=0.
  - lock_loss_cnt is preserved.
- All outputs are registered. domain_rst_n only ever deasserts in RELEASE, and it asserts in the same cycle ready falls.
- Counter widths are sized by $clog2 of their parameter. No counter may wrap: each is cleared on every state entry that uses it.

Test Plan:
Parameters for all scenarios: RESET_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, RELEASE_GAP=2, NUM_DOMAINS=4, MAX_RETRIES=2.
1. Nominal bring-up: release areset_n, then raise pll_locked 5 cycles after pll_areset falls.
   - pll_areset is high for exactly 4 cycles.
   - STABLE is entered 2 cycles after the pll_locked rise.
   - domain_rst_n goes 0001→0011→0111→1111 at 2-cycle spacing.
   - ready=1 one cycle after 1111; state=5.
2. Lock chatter in STABLE: drop pll_locked for 1 cycle at stable count 5, then hold high.
   - Returns to WAIT_LOCK, then re-qualifies with a full 8 cycles; release follows.
   - If the timeout counter reaches 32 first, a timeout is taken instead.
3. Never lock: hold pll_locked=0.
   - Two ASSERT_RST/WAIT_LOCK attempts, each with 32 cycles in WAIT_LOCK.
   - Then FAULT with fault=1, retry_cnt=2, pll_areset=1, domain_rst_n=0000.
4. Lock loss in RUN: drop pll_locked.
   - Within 3 cycles: ready=0, domain_rst_n=0000, pll_areset=1, lock_loss_cnt=1.
   - After relock, the full sequence repeats and lock_loss_cnt stays 1.
5. restart in FAULT and mid-RELEASE (domain_rst_n=0011):
   - Next cycle: state=1, fault=0, retry_cnt=0, domain_rst_n=0000.
6. Async reset mid-RUN: assert areset_n low asynchronously.
   - All outputs reach reset values without a clock edge; lock_loss_cnt=0.
